inst_dispatcher: RTL
====================

INST_DISPATCHER -- requirements
Module: inst_dispatcher

Interface
REQ-001 SHALL have parameter INST_BITS, default 64: instruction word width, matching the systolic array's instruction port.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16 (power of two): instruction queue depth.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 s_inst_valid  in  1  host offers an instruction.
REQ-007 s_inst_data  in  INST_BITS  offered instruction.
REQ-008 s_inst_ready  out  1  queue can accept; asserted when count < FIFO_DEPTH.
REQ-009 run  in  1  issue enable; 0 stalls new issues and does not abort an in-flight instruction.
REQ-010 init_inst_pulse  out  1  instruction request to the systolic array.
REQ-011 instruction  out  INST_BITS  instruction presented to the array.
REQ-012 idle_flag  in  1  array idle indication.
REQ-013 flag  in  1  array completion indication.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries.
REQ-015 issued_count  out  16  completed instructions; wraps 0xFFFF->0.
REQ-016 busy  out  1  FSM not in S_IDLE.
REQ-017 timeout_err  out  1  sticky watchdog error.

Function
REQ-018 Push SHALL occur on a rising edge with s_inst_valid && s_inst_ready; data SHALL be held otherwise.
REQ-019 FIFO SHALL be first-in-first-out; pointers wrap modulo FIFO_DEPTH.
REQ-020 A simultaneous push and pop SHALL both occur and leave fifo_count unchanged.
REQ-021 When full, s_inst_ready SHALL be 0 and the offered word SHALL be neither accepted nor corrupt the queue, even if a pop occurs in the same cycle.
REQ-022 FSM states: S_IDLE, S_ISSUE, S_EXEC, S_DONE.
REQ-023 S_IDLE->S_ISSUE SHALL occur when run=1, fifo_count>0 and idle_flag=1. On this edge the head SHALL pop into the instruction register.
REQ-024 In S_ISSUE, init_inst_pulse SHALL be 1 and instruction SHALL be stable. S_ISSUE->S_EXEC SHALL occur on the first sampled idle_flag=0.
REQ-025 In S_EXEC, init_inst_pulse SHALL be 0 and instruction SHALL hold. S_EXEC->S_DONE SHALL occur on sampled flag=1.
REQ-026 S_DONE SHALL last exactly one cycle, increment issued_count, and return to S_IDLE.
REQ-027 All outputs SHALL be registered. Latency from push into an empty queue (run=1, idle_flag=1) to init_inst_pulse=1 SHALL be 1 cycle.
REQ-028 An empty queue SHALL keep the FSM in S_IDLE with init_inst_pulse=0.
REQ-029 While idle_flag=0 in S_IDLE, issue SHALL be withheld until idle_flag returns to 1.
REQ-030 Deasserting run during S_ISSUE/S_EXEC SHALL NOT abort; the instruction SHALL complete normally.

Reset
REQ-031 When reset=1 at a rising edge, the block SHALL go to S_IDLE and empty the FIFO.
REQ-032 Reset values: init_inst_pulse=0, instruction=0, fifo_count=0, issued_count=0, busy=0, timeout_err=0, s_inst_ready=1 from the first cycle after reset.
REQ-033 Reset mid-instruction SHALL drop both in-flight and queued instructions without completion counting.

Configuration
REQ-034 With INST_DISPATCHER_TIMEOUT_EN defined, a counter SHALL clear on entry to S_ISSUE and count cycles in S_ISSUE/S_EXEC. On reaching TIMEOUT_CYCLES, it SHALL:
- set timeout_err (sticky until reset);
- go to S_IDLE without incrementing issued_count.
REQ-035 Without INST_DISPATCHER_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be constant 0, and the FSM SHALL wait indefinitely.

Verification
REQ-036 Reset, then push 0x...01 with run=1, idle_flag=1 -> init_inst_pulse=1 next cycle, instruction=0x...01.
REQ-037 Array model drops idle_flag 2 cycles after pulse and raises flag 5 cycles later -> pulse falls after idle_flag=0; one S_DONE cycle; issued_count=1.
REQ-038 Push 17 words with run=0 (depth 16) -> s_inst_ready=0 after the 16th, fifo_count=16, 17th word not accepted. Then set run=1 -> 16 issues in push order.
REQ-039 Push and pop in the same cycle at count=5 -> fifo_count stays 5.
REQ-040 Assert reset during S_EXEC with 3 queued -> fifo_count=0, busy=0, issued_count unchanged-to-0.
REQ-041 With macro and TIMEOUT_CYCLES=8, flag never rises -> timeout_err=1 after 8 cycles, FSM in S_IDLE, next instruction issues. Without macro -> FSM stays in S_EXEC and timeout_err=0.

Source files
------------

// File: rtl/inst_dispatcher.sv
// inst_dispatcher: host instruction FIFO feeding a systolic-array issue FSM.
// Optional watchdog is built only when INST_DISPATCHER_TIMEOUT_EN is defined.
module inst_dispatcher #(
  parameter int INST_BITS      = 64,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_inst_valid,
  input  logic [INST_BITS-1:0]        s_inst_data,
  output logic                        s_inst_ready,
  input  logic                        run,
  output logic                        init_inst_pulse,
  output logic [INST_BITS-1:0]        instruction,
  input  logic                        idle_flag,
  input  logic                        flag,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                 issued_count,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [INST_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_nx;
  logic                 push;
  logic                 pop;
  logic                 tmo;

  // ready is registered and exact, so a full queue never takes a push
  assign push = s_inst_valid && s_inst_ready;
  assign pop  = (state == S_IDLE) && run && idle_flag
             && (fifo_count != '0);
  assign count_nx = fifo_count + CW'(push) - CW'(pop);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (pop) state_nx = S_ISSUE;
      S_ISSUE: if (!idle_flag) state_nx = S_EXEC;
      S_EXEC:  if (flag) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (tmo) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_inst_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      s_inst_ready    <= 1'b1;
      instruction     <= '0;
      init_inst_pulse <= 1'b0;
      busy            <= 1'b0;
      issued_count    <= '0;
    end else begin
      state        <= state_nx;
      fifo_count   <= count_nx;
      s_inst_ready <= (count_nx < CW'(FIFO_DEPTH));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        instruction <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + AW'(1);
      end
      init_inst_pulse <= (state_nx == S_ISSUE);
      busy            <= (state_nx != S_IDLE);
      if (state_nx == S_DONE) issued_count <= issued_count + 16'd1;
    end
  end

`ifdef INST_DISPATCHER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;
  logic          wd_err;

  assign tmo = ((state == S_ISSUE) || (state == S_EXEC))
            && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = wd_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (pop) wd_cnt <= '0;
      else if ((state == S_ISSUE) || (state == S_EXEC))
        wd_cnt <= wd_cnt + TW'(1);
      if (tmo) wd_err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule
